// File: rtl/mux_arb_reg.sv
// N-channel registered multiplexer with valid/ready handshakes.
// Selection is either a fixed external index or round-robin among the requesting channels.
module mux_arb_reg #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    localparam int SW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SW-1:0]     out_ch,
    input  logic              out_ready
);

    localparam int unsigned NCH_U = N_CH;

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SW-1:0]   out_ch_q,    out_ch_d;
    logic [SW-1:0]   last_q,      last_d;

    logic            ld;
    logic            grant_any;
    logic [SW-1:0]   grant_idx;
    logic [N_CH-1:0] grant;
    logic [W-1:0]    grant_data;

    always_comb begin
        int unsigned idx;
        idx        = 0;
        grant      = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        if (!mode) begin
            if (int'(sel) < N_CH) begin
                idx = int'(sel);
                if (in_valid[idx]) begin
                    grant_any  = 1'b1;
                    grant_idx  = sel;
                    grant[idx] = 1'b1;
                    grant_data = in_data[idx*W +: W];
                end
            end
        end else begin
            // Search starts just after the last winner and wraps back to channel 0.
            for (int unsigned k = 1; k <= NCH_U; k++) begin
                idx = int'(last_q) + k;
                if (idx >= NCH_U) idx = idx - NCH_U;
                if (!grant_any && in_valid[idx]) begin
                    grant_any  = 1'b1;
                    grant_idx  = SW'(idx);
                    grant[idx] = 1'b1;
                    grant_data = in_data[idx*W +: W];
                end
            end
        end
    end

    always_comb begin
        ld          = ~out_valid_q | out_ready;
        in_ready    = (ld && !rst) ? grant : '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        last_d      = last_q;
        if (ld) begin
            out_valid_d = grant_any;
            if (grant_any) begin
                out_data_d = grant_data;
                out_ch_d   = grant_idx;
                if (mode) last_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            last_q      <= SW'(N_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg: the stimulus process queues the expected words and
// a monitor pops and compares them on every output handshake.
module tb_mux_arb_reg;

    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int SW   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              mode;
    logic [SW-1:0]     sel;
    logic [N_CH-1:0]   in_valid;
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_ch;
    logic              out_ready;

    int total = 0;
    int bad   = 0;

    logic [W+SW-1:0] exp_q[$];

    mux_arb_reg #(.N_CH(N_CH), .W(W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drives one cycle of inputs, checks in_ready, queues the word the hand-computed
    // grant should deliver, then advances to 1ns past the next rising edge.
    task automatic step(input string name, input logic r, input logic m, input logic [SW-1:0] s,
                        input logic [N_CH-1:0] v, input logic ordy, input logic [N_CH-1:0] exp_rdy);
        logic [W-1:0] d;
        rst = r; mode = m; sel = s; in_valid = v; out_ready = ordy;
        #1;
        check({name, ".in_ready"}, 16'(in_ready), 16'(exp_rdy));
        for (int i = 0; i < N_CH; i++) begin
            if (exp_rdy[i]) begin
                d = in_data[i*W +: W];
                exp_q.push_back({d, SW'(i)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: each output handshake must match the oldest queued word.
    initial begin
        logic [W+SW-1:0] e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL monitor: unexpected word ch=%0d data=%h", out_ch, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("monitor.data", 16'(out_data), 16'(e[W+SW-1:SW]));
                    check("monitor.ch", 16'(out_ch), 16'(e[SW-1:0]));
                end
            end
        end
    end

    initial begin
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};

        // reset with all channels requesting
        step("rst0", 1, 0, 0, 4'b1111, 1, 4'b0000);
        check("rst0.out_valid", 16'(out_valid), 16'h0);
        check("rst0.out_data", 16'(out_data), 16'h0);
        check("rst0.out_ch", 16'(out_ch), 16'h0);
        step("rst1", 1, 0, 0, 4'b1111, 1, 4'b0000);
        check("rst1.out_valid", 16'(out_valid), 16'h0);
        check("rst1.out_data", 16'(out_data), 16'h0);

        // fixed mux sweep
        step("fix0", 0, 0, 0, 4'b1111, 1, 4'b0001);
        step("fix1", 0, 0, 1, 4'b1111, 1, 4'b0010);
        step("fix2", 0, 0, 2, 4'b1111, 1, 4'b0100);
        step("fix3", 0, 0, 3, 4'b1111, 1, 4'b1000);

        // fixed mux, selected channel idle
        step("idle", 0, 0, 2, 4'b1011, 1, 4'b0000);
        check("idle.out_valid", 16'(out_valid), 16'h0);

        // round-robin, all requesting: pointer still at 3 from reset
        step("rr0", 0, 1, 0, 4'b1111, 1, 4'b0001);
        step("rr1", 0, 1, 0, 4'b1111, 1, 4'b0010);
        step("rr2", 0, 1, 0, 4'b1111, 1, 4'b0100);
        step("rr3", 0, 1, 0, 4'b1111, 1, 4'b1000);
        step("rr4", 0, 1, 0, 4'b1111, 1, 4'b0001);
        step("rr5", 0, 1, 0, 4'b1111, 1, 4'b0010);
        // channels 1 and 3 only
        step("rra", 0, 1, 0, 4'b1010, 1, 4'b1000);
        step("rrb", 0, 1, 0, 4'b1010, 1, 4'b0010);
        step("rrc", 0, 1, 0, 4'b1010, 1, 4'b1000);
        step("rrd", 0, 1, 0, 4'b1010, 1, 4'b0010);

        // backpressure: ch2 loads, then three stalled cycles
        step("bp_load", 0, 1, 0, 4'b1111, 1, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            step("bp_stall", 0, 1, 0, 4'b1111, 0, 4'b0000);
            check("bp_stall.out_valid", 16'(out_valid), 16'h1);
            check("bp_stall.out_ch", 16'(out_ch), 16'h2);
            check("bp_stall.out_data", 16'(out_data), 16'h33);
        end
        step("bp_release", 0, 1, 0, 4'b1111, 1, 4'b1000);

        // mode switch keeps the RR pointer
        step("ms_rr1", 0, 1, 0, 4'b0010, 1, 4'b0010);
        step("ms_fix3", 0, 0, 3, 4'b1111, 1, 4'b1000);
        step("ms_rr2", 0, 1, 0, 4'b1111, 1, 4'b0100);

        // reset while holding a word, then RR restarts at ch0
        step("mid_rst", 1, 1, 0, 4'b1111, 1, 4'b0000);
        check("mid_rst.out_valid", 16'(out_valid), 16'h0);
        step("post_rst", 0, 1, 0, 4'b1111, 1, 4'b0001);
        step("drain", 0, 1, 0, 4'b0000, 1, 4'b0000);
        check("drain.out_valid", 16'(out_valid), 16'h0);
        step("drain2", 0, 1, 0, 4'b0000, 1, 4'b0000);

        check("queue_empty", 16'(exp_q.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
